// File: rtl/alu_ext_arbiter_pkg.sv
// rtl/alu_ext_arbiter_pkg.sv - shared func codes and FSM encoding for the extended-ALU arbiter
package alu_ext_arbiter_pkg;

    typedef enum logic [2:0] {
        FUNC_MUL   = 3'b000,
        FUNC_UMUL  = 3'b001,
        FUNC_ADDF  = 3'b010,
        FUNC_SUBF  = 3'b011,
        FUNC_MULF  = 3'b100,
        FUNC_ITF   = 3'b101,
        FUNC_FTI   = 3'b110,
        FUNC_UNDEF = 3'b111
    } func_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_RESP    = 2'b11
    } state_e;

    function automatic logic func_is_legal(input logic [2:0] func);
        return func != FUNC_UNDEF;
    endfunction

endpackage

// File: rtl/alu_ext_arbiter_if.sv
// rtl/alu_ext_arbiter_if.sv - one requester's command and response channel
interface alu_ext_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [2:0]        func;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src0;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_zr;
    logic              rsp_neg;
    logic              rsp_err;

    modport master (
        output valid, func, src1, src0, rsp_ready,
        input  ready, rsp_valid, rsp_data, rsp_zr, rsp_neg, rsp_err
    );

    modport slave (
        input  valid, func, src1, src0, rsp_ready,
        output ready, rsp_valid, rsp_data, rsp_zr, rsp_neg, rsp_err
    );
endinterface

// File: rtl/alu_ext_arbiter_rr_arb2.sv
// rtl/alu_ext_arbiter_rr_arb2.sv - 2-way round-robin grant with a one-bit preference pointer
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] accept,
    input  logic       fixed_prio,
    output logic [1:0] gnt
);
    logic prefer1_q;
    logic prefer1_d;

    // Each grant looks only at the other requester, so a grant never depends on its own request.
    always_comb begin
        gnt[0] = ~req[1] | fixed_prio | ~prefer1_q;
        gnt[1] = ~req[0] | (~fixed_prio & prefer1_q);
    end

    always_comb begin
        prefer1_d = prefer1_q;
        if (accept[0]) begin
            prefer1_d = 1'b1;
        end else if (accept[1]) begin
            prefer1_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prefer1_q <= 1'b0;
        end else begin
            prefer1_q <= prefer1_d;
        end
    end
endmodule

// File: rtl/alu_ext_arbiter.sv
// rtl/alu_ext_arbiter.sv - shares one extended ALU between two requesters, one op at a time
module alu_ext_arbiter
    import alu_ext_arbiter_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] BAD_RESULT = 32'hDEADDEAD,
    parameter bit                FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_ext_arbiter_if.slave  r0,
    alu_ext_arbiter_if.slave  r1,
    output logic [2:0]        alu_func,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src0,
    input  logic [DATA_W-1:0] alu_dst,
    input  logic              alu_zr,
    input  logic              alu_neg
);
    state_e            state_q, state_d;
    logic [2:0]        func_q, func_d;
    logic [DATA_W-1:0] src1_q, src1_d;
    logic [DATA_W-1:0] src0_q, src0_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              zr_q, zr_d;
    logic              neg_q, neg_d;
    logic              err_q, err_d;

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic [1:0]        rdy;
    logic [1:0]        accept;
    logic              acc_any;
    logic              acc_id;
    logic [2:0]        sel_func;
    logic [DATA_W-1:0] sel_src1;
    logic [DATA_W-1:0] sel_src0;
    logic              rsp_hs;

    assign req = {r1.valid, r0.valid};

    rr_arb2 u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .accept     (accept),
        .fixed_prio (FIXED_PRIO),
        .gnt        (gnt)
    );

    // Readies are held low while reset is asserted so every output is 0 immediately.
    always_comb begin
        rdy      = (state_q == ST_IDLE && rst_n) ? gnt : 2'b00;
        accept   = req & rdy;
        acc_any  = |accept;
        acc_id   = accept[1];
        sel_func = acc_id ? r1.func : r0.func;
        sel_src1 = acc_id ? r1.src1 : r0.src1;
        sel_src0 = acc_id ? r1.src0 : r0.src0;
        rsp_hs   = owner_q ? r1.rsp_ready : r0.rsp_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (acc_any) begin
                    state_d = func_is_legal(sel_func) ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE:   state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // Illegal ops leave the latched operands untouched so the ALU inputs do not move.
    always_comb begin
        func_d  = func_q;
        src1_d  = src1_q;
        src0_d  = src0_q;
        owner_d = owner_q;
        data_d  = data_q;
        zr_d    = zr_q;
        neg_d   = neg_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (acc_any) begin
                    owner_d = acc_id;
                    if (func_is_legal(sel_func)) begin
                        func_d = sel_func;
                        src1_d = sel_src1;
                        src0_d = sel_src0;
                        err_d  = 1'b0;
                    end else begin
                        data_d = BAD_RESULT;
                        err_d  = 1'b1;
                        zr_d   = 1'b0;
                        neg_d  = 1'b0;
                    end
                end
            end
            ST_ISSUE: begin
                zr_d  = alu_zr;
                neg_d = alu_neg;
            end
            ST_CAPTURE: begin
                data_d = alu_dst;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            func_q  <= 3'b000;
            src1_q  <= '0;
            src0_q  <= '0;
            owner_q <= 1'b0;
            data_q  <= '0;
            zr_q    <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            func_q  <= func_d;
            src1_q  <= src1_d;
            src0_q  <= src0_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            zr_q    <= zr_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        alu_func     = func_q;
        alu_src1     = src1_q;
        alu_src0     = src0_q;

        r0.ready     = rdy[0];
        r1.ready     = rdy[1];

        r0.rsp_valid = (state_q == ST_RESP) && !owner_q;
        r1.rsp_valid = (state_q == ST_RESP) &&  owner_q;

        r0.rsp_data  = owner_q ? '0 : data_q;
        r0.rsp_zr    = owner_q ? 1'b0 : zr_q;
        r0.rsp_neg   = owner_q ? 1'b0 : neg_q;
        r0.rsp_err   = owner_q ? 1'b0 : err_q;

        r1.rsp_data  = owner_q ? data_q : '0;
        r1.rsp_zr    = owner_q ? zr_q  : 1'b0;
        r1.rsp_neg   = owner_q ? neg_q : 1'b0;
        r1.rsp_err   = owner_q ? err_q : 1'b0;
    end
endmodule
